// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: round-robin I/D cache-line refill arbiter on one burst port.
// Lines go out as BEATS write beats; read beats are reassembled into a line.
module line_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_RD_DATA,
    S_WR,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_rr_d;
  logic              r_drop;
  logic              r_side_i;
  logic              r_resp;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BEAT_W-1:0] r_mem_wdata;
  logic [LINE_W-1:0] r_wline;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  logic              w_iv;
  logic              w_dv;
  logic              w_gnt_i;
  logic              w_gnt_wr;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [CW-1:0]     w_nidx;
  logic [BEAT_W-1:0] w_nbeat;
  logic [LINE_W-1:0] w_line_nxt;
  logic              w_i_busy;

  // A flushed I request is not a candidate; ties go to the rr side.
  assign w_iv       = i_req & ~i_flush;
  assign w_dv       = d_req;
  assign w_gnt_i    = w_iv & (~w_dv | ~r_rr_d);
  assign w_gnt_wr   = ~w_gnt_i & d_we;
  assign w_gnt_addr = (w_gnt_i ? i_addr : d_addr) & AMASK;
  assign w_i_busy   = r_side_i &
                      ((r_state == S_RD_CMD) | (r_state == S_RD_DATA));

  always_comb begin
    w_line_nxt = r_line;
    w_line_nxt[int'(r_cnt) * BEAT_W +: BEAT_W] = mem_rdata;
  end

  always_comb begin
    w_nidx  = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    w_nbeat = r_wline[int'(w_nidx) * BEAT_W +: BEAT_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr_d      <= 1'b1;
      r_drop      <= 1'b0;
      r_side_i    <= 1'b0;
      r_resp      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wline     <= '0;
      r_line      <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_resp <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_iv | w_dv) begin
            r_side_i   <= w_gnt_i;
            r_rr_d     <= w_gnt_i;
            r_mem_addr <= w_gnt_addr;
            r_wline    <= d_wdata;
            r_cnt      <= '0;
            if (w_gnt_wr) begin
              r_state     <= S_WR;
              r_mem_write <= 1'b1;
              r_mem_wdata <= d_wdata[BEAT_W-1:0];
            end else begin
              r_state    <= S_RD_CMD;
              r_mem_read <= 1'b1;
            end
          end
        end
        S_RD_CMD: begin
          if (mem_ready) begin
            r_state    <= S_RD_DATA;
            r_mem_read <= 1'b0;
            r_cnt      <= '0;
          end
        end
        S_RD_DATA: begin
          if (mem_rvalid) begin
            r_line <= w_line_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_state    <= S_RESP;
              r_resp     <= 1'b1;
              r_mem_addr <= '0;
              r_cnt      <= '0;
              if (!r_side_i) begin
                r_d_rdata <= w_line_nxt;
              end else if (!(r_drop | i_flush)) begin
                r_i_rdata <= w_line_nxt;
              end
            end
          end
        end
        S_WR: begin
          if (mem_ready) begin
            r_cnt       <= r_cnt + CW'(1);
            r_mem_wdata <= w_nbeat;
            if (r_cnt == LAST) begin
              r_state     <= S_RESP;
              r_resp      <= 1'b1;
              r_mem_write <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
              r_cnt       <= '0;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_drop  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
      // Memory cannot cancel a burst, so a flush only marks it for discard.
      if (w_i_busy && i_flush) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_resp    = r_resp & r_side_i & ~r_drop & ~i_flush;
  assign d_resp    = r_resp & ~r_side_i;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Bench for line_mem_arbiter: vector tables, directed corner sequences
// and a random run against a transaction-level memory/arbiter model.
module tb_line_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_flush;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic         mem_ready;
  logic [63:0]  mem_rdata;
  logic         mem_rvalid;

  line_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          ir, dr, dw, rdy, rv;
    logic [63:0] rd;
    bit          er, ew, eir, edr, ca;
    logic [31:0] ea;
    logic [63:0] ewd;
  } vec_t;

  function automatic vec_t mk(bit ir, bit dr, bit dw, bit rdy, bit rv,
                              logic [63:0] rd, bit er, bit ew, bit eir,
                              bit edr, bit ca, logic [31:0] ea,
                              logic [63:0] ewd);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.er = er; v.ew = ew; v.eir = eir; v.edr = edr; v.ca = ca;
    v.ea = ea; v.ewd = ewd;
    return v;
  endfunction

  task automatic apply(input string nm, input vec_t v);
    i_req = v.ir; d_req = v.dr; d_we = v.dw; i_flush = 1'b0;
    mem_ready = v.rdy; mem_rvalid = v.rv; mem_rdata = v.rd;
    @(negedge clk);
    chk({nm, "_rd"}, mem_read, v.er);
    chk({nm, "_wr"}, mem_write, v.ew);
    chk({nm, "_iresp"}, i_resp, v.eir);
    chk({nm, "_dresp"}, d_resp, v.edr);
    if (v.ca) chk({nm, "_addr"}, mem_addr, v.ea);
    if (v.ew) chk({nm, "_wdata"}, mem_wdata, v.ewd);
    nx();
  endtask

  // One read burst; fb = beat index carrying i_flush (4 = RESP cycle, <0 none).
  task automatic serve(input string nm, input logic [31:0] ea, input bit si,
                       input logic [255:0] ln, input int fb, input int cw,
                       input bit hold);
    int n;
    bit er;
    n = 0;
    while (mem_read !== 1'b1 && n < 30) begin
      nx();
      n++;
    end
    chk({nm, "_cmd"}, mem_read, 1'b1);
    chk({nm, "_addr"}, mem_addr, ea);
    for (int k = 0; k < cw; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = {$urandom, $urandom};
      nx();
    end
    mem_ready = 1'b1;
    mem_rvalid = (cw > 0);
    nx();
    mem_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata = ln[b*64 +: 64];
      if (fb == b) begin
        i_flush = 1'b1;
        i_req = 1'b0;
      end
      @(negedge clk);
      chk({nm, "_baddr"}, mem_addr, ea);
      nx();
      i_flush = 1'b0;
    end
    mem_rvalid = 1'b0;
    if (fb == 4) begin
      i_flush = 1'b1;
      i_req = 1'b0;
    end
    er = (fb < 0);
    @(negedge clk);
    chk({nm, "_iresp"}, i_resp, si && er);
    chk({nm, "_dresp"}, d_resp, !si);
    if (si && er) chk({nm, "_iline"}, i_rdata, ln);
    if (!si) chk({nm, "_dline"}, d_rdata, ln);
    nx();
    i_flush = 1'b0;
    if (!hold) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    @(negedge clk);
    chk({nm, "_once"}, {i_resp, d_resp}, 2'b00);
    nx();
  endtask

  function automatic logic [255:0] rline();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [255:0] mem_m [logic [31:0]];

  function automatic logic [255:0] mline(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  initial begin
    vec_t t2[$];
    vec_t t4[$];
    logic [63:0] b[4];
    logic [63:0] w[4];
    logic [255:0] l2, ld1, ld2, li1, li2, lx, ld3, ly, lz, lw, m_last_d;
    logic [255:0] m_line, m_wline;
    logic [31:0] m_addr;
    int n, m_phase, nphase, cur, m_beat, done;
    bit m_fav_d, m_side_i, m_we, drop_i, drop_d, si;

    b[0] = 64'h1111_1111_1111_1111; b[1] = 64'h2222_2222_2222_2222;
    b[2] = 64'h3333_3333_3333_3333; b[3] = 64'h4444_4444_4444_4444;
    w[0] = 64'hA0A0_0000_0000_00A0; w[1] = 64'hB1B1_1111_0000_00B1;
    w[2] = 64'hC2C2_2222_0000_00C2; w[3] = 64'hD3D3_3333_0000_00D3;
    l2 = {b[3], b[2], b[1], b[0]};

    t2.push_back(mk(1,0,0,0,0,0,    0,0,0,0,1,32'h0,0));
    t2.push_back(mk(1,0,0,1,0,0,    1,0,0,0,1,32'h1040,0));
    for (int k = 0; k < 4; k++)
      t2.push_back(mk(1,0,0,0,1,b[k], 0,0,0,0,1,32'h1040,0));
    t2.push_back(mk(1,0,0,0,0,0,    0,0,1,0,0,32'h0,0));
    t2.push_back(mk(0,0,0,0,0,0,    0,0,0,0,1,32'h0,0));

    t4.push_back(mk(0,1,1,0,0,0, 0,0,0,0,1,32'h0,0));
    t4.push_back(mk(0,1,1,1,0,0, 0,1,0,0,1,32'h8000_0020,w[0]));
    t4.push_back(mk(0,1,1,0,0,0, 0,1,0,0,1,32'h8000_0020,w[1]));
    t4.push_back(mk(0,1,1,0,0,0, 0,1,0,0,1,32'h8000_0020,w[1]));
    t4.push_back(mk(0,1,1,1,0,0, 0,1,0,0,1,32'h8000_0020,w[1]));
    t4.push_back(mk(0,1,1,1,0,0, 0,1,0,0,1,32'h8000_0020,w[2]));
    t4.push_back(mk(0,1,1,1,0,0, 0,1,0,0,1,32'h8000_0020,w[3]));
    t4.push_back(mk(0,1,1,0,0,0, 0,0,0,1,0,32'h0,0));
    t4.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1,32'h0,0));

    ld1 = rline(); ld2 = rline(); li1 = rline(); li2 = rline();
    lx = rline(); ld3 = rline(); ly = rline(); lz = rline(); lw = rline();

    // Reset with both requests up, then D wins first, then strict alternation.
    rst = 1'b0; i_flush = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; d_wdata = '0; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    i_addr = 32'h0000_3064; d_addr = 32'h8000_0158;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read", mem_read, 1'b0);
    chk("rst_write", mem_write, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 64'h0);
    chk("rst_resp", {i_resp, d_resp}, 2'b00);
    chk("rst_irdata", i_rdata, 256'h0);
    chk("rst_drdata", d_rdata, 256'h0);
    nx();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_idle", mem_read, 1'b0);
    nx();
    chk("rel_d_first", mem_read, 1'b1);
    serve("t3_d0", 32'h8000_0140, 1'b0, ld1, -1, 0, 1'b1);
    serve("t3_i0", 32'h0000_3060, 1'b1, li1, -1, 0, 1'b1);
    serve("t3_d1", 32'h8000_0140, 1'b0, ld2, -1, 0, 1'b1);
    serve("t3_i1", 32'h0000_3060, 1'b1, li2, -1, 0, 1'b0);

    i_addr = 32'h0000_1044;
    foreach (t2[k]) apply($sformatf("t2_c%0d", k + 1), t2[k]);
    chk("t2_line", i_rdata, l2);

    d_addr = 32'h8000_0020;
    d_wdata = {w[3], w[2], w[1], w[0]};
    foreach (t4[k]) apply($sformatf("t4_c%0d", k + 1), t4[k]);
    chk("t4_drdata_kept", d_rdata, ld2);

    // Flush on beat 1 of an I refill while a D read waits behind it.
    i_req = 1'b1; i_addr = 32'h0000_2008; d_we = 1'b0;
    nx();
    d_req = 1'b1; d_addr = 32'h8000_0300;
    serve("t5_i", 32'h0000_2000, 1'b1, lx, 1, 0, 1'b1);
    chk("t5_dgrant", mem_read, 1'b1);
    chk("t5_daddr", mem_addr, 32'h8000_0300);
    serve("t5_d", 32'h8000_0300, 1'b0, ld3, -1, 0, 1'b0);
    chk("t5_irdata_kept", i_rdata, l2);

    i_req = 1'b1; i_addr = 32'h0000_4000;
    serve("t5_rflush", 32'h0000_4000, 1'b1, ly, 4, 0, 1'b0);

    // Stray beats in IDLE and RD_CMD must not be captured.
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      chk("t6_idle", {mem_read, i_resp, d_resp}, 3'b000);
      nx();
    end
    mem_rvalid = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_5000;
    serve("t6_spur", 32'h0000_5000, 1'b1, lz, -1, 2, 1'b0);

    i_req = 1'b1; i_addr = 32'h0000_6010;
    n = 0;
    while (mem_read !== 1'b1 && n < 30) begin
      nx();
      n++;
    end
    chk("t6_cmd2", mem_read, 1'b1);
    mem_ready = 1'b1;
    nx();
    mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = {$urandom, $urandom};
      nx();
    end
    mem_rvalid = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_out", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
    chk("t6_rst_addr", mem_addr, 32'h0);
    chk("t6_rst_irdata", i_rdata, 256'h0);
    nx();
    rst = 1'b1;
    serve("t6_after", 32'h0000_6000, 1'b1, lw, -1, 0, 1'b0);

    // Random traffic against a transaction-level memory and arbiter model.
    rst = 1'b0;
    nx();
    rst = 1'b1;
    m_phase = 0; m_fav_d = 1'b1; m_side_i = 1'b0; m_we = 1'b0;
    m_beat = 0; m_addr = '0; m_line = '0; m_wline = '0; m_last_d = '0;
    drop_i = 1'b0; drop_d = 1'b0; done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cur = m_phase;
      nphase = m_phase;
      mem_ready = 1'($urandom % 2);
      mem_rvalid = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (drop_i) i_req = 1'b0;
      if (drop_d) d_req = 1'b0;
      drop_i = 1'b0;
      drop_d = 1'b0;
      if (!i_req && $urandom % 3 == 0) begin
        i_req = 1'b1;
        i_addr = 32'h0000_1000 + ($urandom_range(0, 7) << 5)
               + $urandom_range(0, 31);
      end
      if (!d_req && $urandom % 3 == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom % 2);
        d_addr = 32'h8000_1000 + ($urandom_range(0, 7) << 5)
               + $urandom_range(0, 31);
        d_wdata = rline();
      end else if (d_req && cur != 0 && !m_side_i) begin
        d_we = 1'($urandom % 2);
        d_wdata = rline();
      end
      case (cur)
        0: begin
          mem_rvalid = 1'($urandom % 2);
          chk("r_idle", {mem_read, mem_write}, 2'b00);
        end
        1: begin
          chk("r_cmd", {mem_read, mem_write}, 2'b10);
          chk("r_cmd_addr", mem_addr, m_addr);
          mem_rvalid = 1'($urandom % 2);
          if (mem_ready) begin
            nphase = 2;
            m_beat = 0;
          end
        end
        2: begin
          chk("r_data", {mem_read, mem_write}, 2'b00);
          chk("r_data_addr", mem_addr, m_addr);
          if ($urandom % 2 == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = m_line[m_beat*64 +: 64];
            m_beat++;
            if (m_beat == 4) nphase = 4;
          end
        end
        3: begin
          chk("r_wr", {mem_read, mem_write}, 2'b01);
          chk("r_wr_addr", mem_addr, m_addr);
          chk("r_wr_beat", mem_wdata, m_wline[m_beat*64 +: 64]);
          if (mem_ready) begin
            m_beat++;
            if (m_beat == 4) begin
              mem_m[m_addr] = m_wline;
              nphase = 4;
            end
          end
        end
        default: begin
          chk("r_resp_cyc", {mem_read, mem_write}, 2'b00);
          mem_rvalid = 1'($urandom % 2);
          nphase = 0;
        end
      endcase
      if (cur == 0 && (i_req || d_req)) begin
        si = i_req && (!d_req || !m_fav_d);
        m_fav_d = si;
        m_side_i = si;
        m_addr = (si ? i_addr : d_addr) & ~32'h1F;
        m_we = !si && d_we;
        m_wline = d_wdata;
        m_line = mline(m_addr);
        m_beat = 0;
        nphase = m_we ? 3 : 1;
      end
      m_phase = nphase;
      @(negedge clk);
      chk("r_iresp", i_resp, cur == 4 && m_side_i);
      chk("r_dresp", d_resp, cur == 4 && !m_side_i);
      if (cur == 4) begin
        if (m_side_i) begin
          chk("r_iline", i_rdata, m_line);
          drop_i = 1'b1;
        end else begin
          if (m_we) begin
            chk("r_dkeep", d_rdata, m_last_d);
          end else begin
            chk("r_dline", d_rdata, m_line);
            m_last_d = m_line;
          end
          drop_d = 1'b1;
        end
        done++;
      end
      nx();
    end
    chk("r_progress", done >= 50, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
